// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, frame
// layout constants and small helpers used by the RTL and its bench.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int HDR_LEN    = 2;
    localparam int CSUM_LEN   = 1;
    localparam int WORD_BYTES = 4;

    // Total frame length in bytes for a header word count n.
    function automatic logic [17:0] frame_len(logic [15:0] n);
        return 18'(HDR_LEN + WORD_BYTES * int'(n) + CSUM_LEN);
    endfunction

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(state_t s);
        return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
    endfunction

    // States in which an idle stream counts towards the timeout.
    function automatic logic times_out_in(state_t s);
        return (s == HDR1) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int IMEM_WORDS = 32
) ();
    localparam int AW = $clog2(IMEM_WORDS);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    // Environment side: sources bytes, observes memory writes.
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Collects payload bytes into 32-bit little-endian words; word_done pulses
// for one cycle after the fourth byte of a word, with word stable then.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0] cnt;

    // Shift each byte in from the top so the first byte ends up in [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            word      <= 32'd0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clr) begin
                cnt <= 2'd0;
            end else if (in_vld) begin
                word      <= {in_byte, word[31:8]};
                cnt       <= cnt + 2'd1;
                word_done <= (cnt == 2'd3);
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes
// it into instruction memory and releases the core once the checksum holds.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 32,
    parameter int TIMEOUT    = 1000
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    input  logic         start,
    output logic         cpu_rst,
    output logic         done,
    output logic         error
);
    localparam int            AW        = $clog2(IMEM_WORDS);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [15:0]   MAX_WORDS = 16'(IMEM_WORDS);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    state_t        state;
    state_t        nxt;
    logic          ready_r;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    n_lo;
    logic [15:0]   n_words;
    logic [17:0]   byte_cnt;
    logic [7:0]    csum;
    logic [AW-1:0] addr;

    logic          hs;
    logic          tmo;
    logic          start_ok;
    logic          pay_vld;
    logic          last_pay;
    logic [15:0]   n_hdr;

    assign hs       = bus.byte_valid && ready_r;
    // A timeout beats a handshake arriving in the same cycle.
    assign tmo      = times_out_in(state) && (tmo_cnt == TMO_LIMIT);
    assign start_ok = start && ((state == DONE) || (state == ERR));
    assign pay_vld  = hs && !tmo && (state == DATA);
    assign n_hdr    = {bus.byte_data, n_lo};
    assign last_pay = (byte_cnt == frame_len(n_words) - 18'(CSUM_LEN + 1));

    assign bus.byte_ready = ready_r;
    assign bus.imem_addr  = addr;

    // Next-state decision from the current state and this cycle's byte.
    always_comb begin
        nxt = state;
        case (state)
            HDR0: if (hs) nxt = HDR1;
            HDR1: begin
                if (tmo)                     nxt = ERR;
                else if (hs) begin
                    if (n_hdr == 16'd0)      nxt = CSUM;
                    else if (n_hdr > MAX_WORDS) nxt = ERR;
                    else                     nxt = DATA;
                end
            end
            DATA: begin
                if (tmo)                     nxt = ERR;
                else if (hs && last_pay)     nxt = CSUM;
            end
            CSUM: begin
                if (tmo)                     nxt = ERR;
                else if (hs)                 nxt = (bus.byte_data == csum) ? DONE : ERR;
            end
            DONE, ERR: if (start)            nxt = HDR0;
            default:                         nxt = HDR0;
        endcase
    end

    // State, registered status outputs, frame counters and write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR0;
            ready_r  <= 1'b1;
            cpu_rst  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            tmo_cnt  <= '0;
            n_lo     <= 8'd0;
            n_words  <= 16'd0;
            byte_cnt <= 18'd0;
            csum     <= 8'd0;
            addr     <= '0;
        end else begin
            state   <= nxt;
            ready_r <= accepts_bytes(nxt);
            cpu_rst <= (nxt == DONE);
            done    <= (nxt == DONE);
            error   <= (nxt == ERR);

            if (hs || !times_out_in(state)) tmo_cnt <= '0;
            else                            tmo_cnt <= tmo_cnt + TW'(1);

            if (hs && !tmo) byte_cnt <= byte_cnt + 18'd1;
            if (hs && (state == HDR0)) n_lo <= bus.byte_data;
            if (hs && !tmo && (state == HDR1)) n_words <= n_hdr;
            if (pay_vld) csum <= csum + bus.byte_data;

            // Advance only while another word is still due, so the
            // address never runs past N-1.
            if (bus.imem_we && ((16'(addr) + 16'd1) < n_words)) addr <= addr + AW'(1);

            if (start_ok) begin
                byte_cnt <= 18'd0;
                csum     <= 8'd0;
                addr     <= '0;
                n_words  <= 16'd0;
            end
        end
    end

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .in_vld    (pay_vld),
        .in_byte   (bus.byte_data),
        .word      (bus.imem_wdata),
        .word_done (bus.imem_we)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a frame-level model predicts every output each
// cycle, directed frames pin known results, random frames exercise the rest.
`timescale 1ns/1ps
module tb_prog_loader;
    import loader_pkg::*;

    localparam int IMEM_WORDS = 32;
    localparam int TIMEOUT    = 20;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst, done, error;

    prog_loader_if #(.IMEM_WORDS(IMEM_WORDS)) bus ();

    prog_loader #(.IMEM_WORDS(IMEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .start   (start),
        .cpu_rst (cpu_rst),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // m_fin: 0 = still taking bytes, 1 = image accepted, 2 = load failed.
    bit          armed = 1'b0;
    int          m_fin, m_cnt, m_n, m_nlo, m_sum, m_idle, m_addr, m_wr_total;
    bit          m_we, m_rst_seen;
    logic [31:0] m_wdata;
    logic [7:0]  m_pay[$];

    task automatic accept(input int b);
        if (m_cnt == 0) begin
            m_nlo = b;
        end else if (m_cnt == HDR_LEN - 1) begin
            m_n = b * 256 + m_nlo;
            if (m_n > IMEM_WORDS) m_fin = 2;
        end else if (m_cnt < HDR_LEN + WORD_BYTES * m_n) begin
            m_pay.push_back(b[7:0]);
            m_sum = (m_sum + b) % 256;
            if (m_pay.size() % WORD_BYTES == 0) begin
                int k;
                k       = m_pay.size() / WORD_BYTES - 1;
                m_we    = 1'b1;
                m_addr  = k;
                m_wdata = {m_pay[4*k+3], m_pay[4*k+2], m_pay[4*k+1], m_pay[4*k]};
                m_wr_total++;
            end
        end else begin
            m_fin = (b == m_sum) ? 1 : 2;
        end
    endtask

    always @(posedge clk) begin : model
        bit hs_m;
        if (rst) begin
            armed = 1'b1; m_fin = 0; m_cnt = 0; m_n = 0; m_nlo = 0; m_sum = 0;
            m_idle = 0; m_we = 1'b0; m_rst_seen = 1'b1; m_pay.delete();
        end else begin
            m_we = 1'b0;
            m_rst_seen = 1'b0;
            hs_m = bus.byte_valid && (m_fin == 0);
            if (m_fin == 0) begin
                if (m_cnt > 0 && m_idle == TIMEOUT) m_fin = 2;
                else if (hs_m) begin
                    accept(int'(bus.byte_data));
                    m_cnt++;
                    m_idle = 0;
                end else if (m_cnt > 0) m_idle++;
            end else if (start) begin
                m_fin = 0; m_cnt = 0; m_sum = 0; m_idle = 0; m_pay.delete();
            end
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          dut_wr_total = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("byte_ready", 32'(bus.byte_ready), 32'(m_fin == 0));
            chk("done",       32'(done),           32'(m_fin == 1));
            chk("error",      32'(error),          32'(m_fin == 2));
            chk("cpu_rst",    32'(cpu_rst),        32'(m_fin == 1));
            chk("imem_we",    32'(bus.imem_we),    32'(m_we));
            if (m_we) begin
                chk("imem_addr",  32'(bus.imem_addr), 32'(m_addr));
                chk("imem_wdata", bus.imem_wdata,     m_wdata);
            end
            if (m_rst_seen) begin
                chk("rst_addr",  32'(bus.imem_addr), 32'd0);
                chk("rst_wdata", bus.imem_wdata,     32'd0);
            end
            if (bus.imem_we === 1'b1) begin
                wr_addr.push_back(32'(bus.imem_addr));
                wr_data.push_back(bus.imem_wdata);
                dut_wr_total++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.byte_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Sends q; gap_at/gap_len force one idle stretch, rnd adds random gaps
    // and stray start pulses, rst_at pulses rst instead of sending that byte.
    task automatic send_frame(input logic [7:0] q[$], input int gap_at, input int gap_len,
                              input bit rnd, input int rst_at);
        for (int i = 0; i < q.size(); i++) begin
            int gap;
            gap = 0;
            if (i == gap_at) gap = gap_len;
            else if (rnd) gap = ($urandom_range(0, 29) == 0) ? TIMEOUT - 1 + $urandom_range(0, 2)
                                                             : $urandom_range(0, 2);
            if (i == rst_at) begin
                @(negedge clk); bus.byte_valid = 1'b0; start = 1'b0; rst = 1'b1;
                @(negedge clk); rst = 1'b0;
                return;
            end
            idle(gap);
            @(negedge clk);
            if (m_fin != 0) begin
                bus.byte_valid = 1'b0;
                start = 1'b0;
                return;
            end
            start = rnd && ($urandom_range(0, 15) == 0);
            bus.byte_valid = 1'b1;
            bus.byte_data  = q[i];
        end
        idle(1);
    endtask

    task automatic wait_fin(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_fin != 0) begin ok = 1'b1; break; end
            idle(1);
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s_wait: frame still open after %0d cycles, required closed", name, budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] fa[$];
        logic [7:0] q[$];

        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        idle(2);
        chk("rst_ready",   32'(bus.byte_ready), 32'd1);
        chk("rst_done",    32'(done),           32'd0);
        chk("rst_error",   32'(error),          32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst),        32'd0);
        chk("rst_we",      32'(bus.imem_we),    32'd0);
        rst = 1'b0;
        idle(1);

        // N=2 image; payload bytes 13+33+02+21 sum to 0x69.
        fa = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00, 8'h69};
        wr_addr.delete(); wr_data.delete();
        send_frame(fa, -1, 0, 1'b0, -1);
        wait_fin(50, "good"); idle(2);
        chk("good_nwr",   32'(wr_addr.size()), 32'd2);
        chk("good_addr0", wr_addr[0], 32'd0);
        chk("good_data0", wr_data[0], 32'h0000_0013);
        chk("good_addr1", wr_addr[1], 32'd1);
        chk("good_data1", wr_data[1], 32'h0021_0233);
        chk("good_done",  32'(done),    32'd1);
        chk("good_cpu",   32'(cpu_rst), 32'd1);
        chk("good_ready", 32'(bus.byte_ready), 32'd0);
        pulse_start();
        chk("rearm_ready", 32'(bus.byte_ready), 32'd1);
        chk("rearm_done",  32'(done), 32'd0);

        // Same image, wrong checksum bytes.
        foreach (fa[i]) q[i] = fa[i];
        q = fa; q[10] = 8'h00;
        wr_addr.delete(); wr_data.delete();
        send_frame(q, -1, 0, 1'b0, -1);
        wait_fin(50, "badsum"); idle(2);
        chk("badsum_nwr",   32'(wr_addr.size()), 32'd2);
        chk("badsum_error", 32'(error),   32'd1);
        chk("badsum_cpu",   32'(cpu_rst), 32'd0);
        pulse_start();
        q = fa; q[10] = 8'h79;
        send_frame(q, -1, 0, 1'b0, -1);
        wait_fin(50, "sum79"); idle(1);
        chk("sum79_error", 32'(error), 32'd1);
        pulse_start();

        // Oversized header: 33 words into a 32-word memory.
        q = '{8'h21, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        wr_addr.delete();
        send_frame(q, -1, 0, 1'b0, -1);
        wait_fin(50, "big"); idle(3);
        chk("big_error", 32'(error), 32'd1);
        chk("big_nwr",   32'(wr_addr.size()), 32'd0);
        pulse_start();

        // Empty image.
        q = '{8'h00, 8'h00, 8'h00};
        wr_addr.delete();
        send_frame(q, -1, 0, 1'b0, -1);
        wait_fin(50, "empty"); idle(1);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_nwr",  32'(wr_addr.size()), 32'd0);
        pulse_start();

        // Stall of exactly TIMEOUT idle cycles mid-word: the timeout wins.
        q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
        wr_addr.delete();
        send_frame(q, 4, TIMEOUT, 1'b0, -1);
        wait_fin(50, "tmo"); idle(1);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_nwr",   32'(wr_addr.size()), 32'd0);
        pulse_start();
        chk("tmo_rearm_ready", 32'(bus.byte_ready), 32'd1);
        chk("tmo_rearm_error", 32'(error), 32'd0);

        // One cycle shorter stall is still accepted.
        wr_addr.delete(); wr_data.delete();
        send_frame(q, 4, TIMEOUT - 1, 1'b0, -1);
        wait_fin(50, "slow"); idle(2);
        chk("slow_done", 32'(done), 32'd1);
        chk("slow_nwr",  32'(wr_addr.size()), 32'd1);
        chk("slow_data", wr_data[0], 32'hDDCC_BBAA);
        pulse_start();

        // Reset after the third payload byte, then a clean reload.
        wr_addr.delete();
        send_frame(fa, -1, 0, 1'b0, 5);
        chk("midrst_ready", 32'(bus.byte_ready), 32'd1);
        chk("midrst_done",  32'(done),  32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        chk("midrst_addr",  32'(bus.imem_addr), 32'd0);
        chk("midrst_wdata", bus.imem_wdata, 32'd0);
        chk("midrst_nwr",   32'(wr_addr.size()), 32'd0);
        wr_addr.delete(); wr_data.delete();
        send_frame(fa, -1, 0, 1'b0, -1);
        wait_fin(50, "reload"); idle(2);
        chk("reload_nwr",   32'(wr_addr.size()), 32'd2);
        chk("reload_data1", wr_data[1], 32'h0021_0233);
        chk("reload_done",  32'(done), 32'd1);
        pulse_start();

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            int n, sum, rst_at;
            n = $urandom_range(0, IMEM_WORDS + 2);
            q = '{8'(n), 8'(n >> 8)};
            sum = 0;
            for (int i = 0; i < WORD_BYTES * ((n > IMEM_WORDS) ? 1 : n); i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                q.push_back(b);
                sum = (sum + int'(b)) % 256;
            end
            if ($urandom_range(0, 3) == 0) q.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
            else                           q.push_back(8'(sum));
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, q.size() - 1) : -1;
            send_frame(q, -1, 0, 1'b1, rst_at);
            if (rst_at < 0) begin
                wait_fin(4 * TIMEOUT + 50, "rand");
                idle($urandom_range(0, 3));
                pulse_start();
            end
        end
        idle(3);
        chk("wr_total", 32'(dut_wr_total), 32'(m_wr_total));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
